// File: rtl/lieat_ifu_fetch_ctrl.sv
// IFU fetch sequencer: owns the PC, keeps one fetch outstanding, applies static prediction
// and hands instructions to decode through a one-entry valid/ready register.
`timescale 1ns/1ps
module lieat_ifu_fetch_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     REG_IDX  = 5,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               req_valid_o,
    input  logic               req_ready_i,
    output logic [XLEN-1:0]    req_addr_o,
    input  logic               rsp_valid_i,
    input  logic [XLEN-1:0]    rsp_inst_i,
    input  logic               rsp_err_i,
    input  logic               pre_bxx_i,
    input  logic               pre_jal_i,
    input  logic               pre_jalr_i,
    input  logic               pre_fencei_i,
    input  logic [XLEN-1:0]    pre_imm_i,
    input  logic [REG_IDX-1:0] pre_rs1_i,
    output logic [REG_IDX-1:0] jalr_rs1_idx_o,
    input  logic               jalr_rs1_busy_i,
    input  logic [XLEN-1:0]    jalr_rs1_rdata_i,
    output logic               fencei_req_o,
    input  logic               fencei_done_i,
    input  logic               exu_redirect_i,
    input  logic [XLEN-1:0]    exu_redirect_pc_i,
    output logic               ifu_valid_o,
    input  logic               ifu_ready_i,
    output logic [XLEN-1:0]    ifu_inst_o,
    output logic [XLEN-1:0]    ifu_pc_o,
    output logic               ifu_pred_taken_o,
    output logic               ifu_err_o
);

    localparam logic [2:0] StFetch = 3'd0;
    localparam logic [2:0] StWait  = 3'd1;
    localparam logic [2:0] StDrop  = 3'd2;
    localparam logic [2:0] StJwait = 3'd3;
    localparam logic [2:0] StFwait = 3'd4;
    localparam logic [2:0] StHalt  = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [XLEN-1:0]    inst_q, inst_d;
    logic [XLEN-1:0]    opc_q, opc_d;
    logic               pred_q, pred_d;
    logic               err_q, err_d;
    logic [REG_IDX-1:0] jidx_q, jidx_d;
    logic [XLEN-1:0]    jimm_q, jimm_d;

    logic slot_free;
    logic req_hs;
    logic in_flight;

    always_comb begin
        slot_free = ~valid_q | ifu_ready_i;
        req_hs    = (state_q == StFetch) & slot_free & req_ready_i;
        // A request is in flight if one was already accepted or is being accepted right now.
        in_flight = (state_q == StWait) | (state_q == StDrop) | req_hs;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q & ~ifu_ready_i;
        inst_d  = inst_q;
        opc_d   = opc_q;
        pred_d  = pred_q;
        err_d   = err_q;
        jidx_d  = jidx_q;
        jimm_d  = jimm_q;

        case (state_q)
            StFetch: begin
                if (req_hs) state_d = StWait;
            end
            StWait: begin
                if (rsp_valid_i) begin
                    inst_d  = rsp_inst_i;
                    opc_d   = pc_q;
                    valid_d = 1'b1;
                    pred_d  = 1'b0;
                    err_d   = 1'b0;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = StFetch;
                    if (rsp_err_i) begin
                        err_d   = 1'b1;
                        pc_d    = pc_q;
                        state_d = StHalt;
                    end else if (pre_jal_i || (pre_bxx_i && pre_imm_i[XLEN-1])) begin
                        pc_d   = pc_q + pre_imm_i;
                        pred_d = 1'b1;
                    end else if (pre_bxx_i) begin
                        pred_d = 1'b0;
                    end else if (pre_jalr_i) begin
                        // Held back until the rs1 operand is readable.
                        valid_d = 1'b0;
                        jidx_d  = pre_rs1_i;
                        jimm_d  = pre_imm_i;
                        pc_d    = pc_q;
                        state_d = StJwait;
                    end else if (pre_fencei_i) begin
                        state_d = StFwait;
                    end
                end
            end
            StJwait: begin
                if (!jalr_rs1_busy_i && slot_free) begin
                    valid_d = 1'b1;
                    pred_d  = 1'b1;
                    err_d   = 1'b0;
                    pc_d    = jalr_rs1_rdata_i + jimm_q;
                    state_d = StFetch;
                end
            end
            StFwait: begin
                if (fencei_done_i) state_d = StFetch;
            end
            StDrop: begin
                if (rsp_valid_i) state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StFetch;
        endcase

        if (exu_redirect_i) begin
            pc_d    = exu_redirect_pc_i;
            valid_d = 1'b0;
            inst_d  = inst_q;
            opc_d   = opc_q;
            pred_d  = pred_q;
            err_d   = err_q;
            jidx_d  = jidx_q;
            jimm_d  = jimm_q;
            state_d = (in_flight && !rsp_valid_i) ? StDrop : StFetch;
        end

        pc_d[1:0] = 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= '0;
            opc_q   <= '0;
            pred_q  <= 1'b0;
            err_q   <= 1'b0;
            jidx_q  <= '0;
            jimm_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
            pred_q  <= pred_d;
            err_q   <= err_d;
            jidx_q  <= jidx_d;
            jimm_q  <= jimm_d;
        end
    end

    always_comb begin
        // Gated by rst_n so no request is presented while reset is held.
        req_valid_o      = rst_n & (state_q == StFetch) & slot_free;
        req_addr_o       = pc_q;
        fencei_req_o     = (state_q == StFwait);
        jalr_rs1_idx_o   = jidx_q;
        ifu_valid_o      = valid_q;
        ifu_inst_o       = inst_q;
        ifu_pc_o         = opc_q;
        ifu_pred_taken_o = pred_q;
        ifu_err_o        = err_q;
    end

endmodule

// File: tb/tb_lieat_ifu_fetch_ctrl.sv
// Directed bench for lieat_ifu_fetch_ctrl: hand-sequenced fetches with fixed expected values.
`timescale 1ns/1ps
module tb_lieat_ifu_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic        rsp_err;
    logic        pre_bxx, pre_jal, pre_jalr, pre_fencei;
    logic [31:0] pre_imm;
    logic [4:0]  pre_rs1;
    logic [4:0]  jalr_rs1_idx;
    logic        jalr_rs1_busy;
    logic [31:0] jalr_rs1_rdata;
    logic        fencei_req;
    logic        fencei_done;
    logic        exu_redirect;
    logic [31:0] exu_redirect_pc;
    logic        ifu_valid;
    logic        ifu_ready;
    logic [31:0] ifu_inst;
    logic [31:0] ifu_pc;
    logic        ifu_pred_taken;
    logic        ifu_err;

    int n_pass;
    int n_total;

    lieat_ifu_fetch_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_o       (req_valid),
        .req_ready_i       (req_ready),
        .req_addr_o        (req_addr),
        .rsp_valid_i       (rsp_valid),
        .rsp_inst_i        (rsp_inst),
        .rsp_err_i         (rsp_err),
        .pre_bxx_i         (pre_bxx),
        .pre_jal_i         (pre_jal),
        .pre_jalr_i        (pre_jalr),
        .pre_fencei_i      (pre_fencei),
        .pre_imm_i         (pre_imm),
        .pre_rs1_i         (pre_rs1),
        .jalr_rs1_idx_o    (jalr_rs1_idx),
        .jalr_rs1_busy_i   (jalr_rs1_busy),
        .jalr_rs1_rdata_i  (jalr_rs1_rdata),
        .fencei_req_o      (fencei_req),
        .fencei_done_i     (fencei_done),
        .exu_redirect_i    (exu_redirect),
        .exu_redirect_pc_i (exu_redirect_pc),
        .ifu_valid_o       (ifu_valid),
        .ifu_ready_i       (ifu_ready),
        .ifu_inst_o        (ifu_inst),
        .ifu_pc_o          (ifu_pc),
        .ifu_pred_taken_o  (ifu_pred_taken),
        .ifu_err_o         (ifu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer the request and expect it to be presented at the given address.
    task automatic issue(input logic [31:0] addr);
        req_ready = 1'b1;
        #1;
        chk("req_valid", {31'd0, req_valid}, 32'd1);
        chk("req_addr", req_addr, addr);
        tick();
        req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] inst, input logic err, input logic bxx,
                           input logic jal, input logic jalr, input logic fencei,
                           input logic [31:0] imm, input logic [4:0] rs1);
        rsp_valid  = 1'b1;
        rsp_inst   = inst;
        rsp_err    = err;
        pre_bxx    = bxx;
        pre_jal    = jal;
        pre_jalr   = jalr;
        pre_fencei = fencei;
        pre_imm    = imm;
        pre_rs1    = rs1;
        tick();
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        pre_bxx    = 1'b0;
        pre_jal    = 1'b0;
        pre_jalr   = 1'b0;
        pre_fencei = 1'b0;
        pre_imm    = '0;
        pre_rs1    = '0;
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_inst = '0;
        rsp_err = 1'b0;
        pre_bxx = 1'b0;
        pre_jal = 1'b0;
        pre_jalr = 1'b0;
        pre_fencei = 1'b0;
        pre_imm = '0;
        pre_rs1 = '0;
        jalr_rs1_busy = 1'b0;
        jalr_rs1_rdata = '0;
        fencei_done = 1'b0;
        exu_redirect = 1'b0;
        exu_redirect_pc = '0;
        ifu_ready = 1'b1;

        #12;
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_req_addr", req_addr, 32'h8000_0000);
        chk("rst_ifu_valid", {31'd0, ifu_valid}, 32'd0);
        chk("rst_fencei_req", {31'd0, fencei_req}, 32'd0);
        chk("rst_jalr_idx", {27'd0, jalr_rs1_idx}, 32'd0);
        chk("rst_ifu_err", {31'd0, ifu_err}, 32'd0);
        chk("rst_pred", {31'd0, ifu_pred_taken}, 32'd0);
        tick();
        rst_n = 1'b1;

        // First fetch: nop at the reset PC
        issue(32'h8000_0000);
        #1;
        chk("wait_no_req", {31'd0, req_valid}, 32'd0);
        respond(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
        chk("nop_valid", {31'd0, ifu_valid}, 32'd1);
        chk("nop_pc", ifu_pc, 32'h8000_0000);
        chk("nop_inst", ifu_inst, 32'h0000_0013);
        chk("nop_pred", {31'd0, ifu_pred_taken}, 32'd0);
        chk("nop_next_addr", req_addr, 32'h8000_0004);

        for (int i = 1; i < 4; i++) begin
            issue(32'h8000_0000 + 32'(4 * i));
            respond(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
        end

        // Backward branch is predicted taken
        issue(32'h8000_0010);
        respond(32'hFE00_0CE3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 5'd0);
        chk("bwd_valid", {31'd0, ifu_valid}, 32'd1);
        chk("bwd_pc", ifu_pc, 32'h8000_0010);
        chk("bwd_pred", {31'd0, ifu_pred_taken}, 32'd1);
        chk("bwd_next_addr", req_addr, 32'h8000_0008);

        // Redirect with no request in flight; low target bits are dropped
        exu_redirect = 1'b1;
        exu_redirect_pc = 32'h8000_0012;
        tick();
        exu_redirect = 1'b0;
        #1;
        chk("redir_fetch_addr", req_addr, 32'h8000_0010);
        chk("redir_fetch_req", {31'd0, req_valid}, 32'd1);
        chk("redir_fetch_ifu_valid", {31'd0, ifu_valid}, 32'd0);

        // Forward branch is predicted not taken
        issue(32'h8000_0010);
        respond(32'h0000_0463, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 5'd0);
        chk("fwd_valid", {31'd0, ifu_valid}, 32'd1);
        chk("fwd_pred", {31'd0, ifu_pred_taken}, 32'd0);
        chk("fwd_next_addr", req_addr, 32'h8000_0014);

        // jalr waits for its operand
        jalr_rs1_busy = 1'b1;
        issue(32'h8000_0014);
        respond(32'h0042_8067, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 5'd5);
        chk("jalr_hold_valid", {31'd0, ifu_valid}, 32'd0);
        chk("jalr_idx", {27'd0, jalr_rs1_idx}, 32'd5);
        chk("jalr_no_req", {31'd0, req_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("jalr_busy_valid", {31'd0, ifu_valid}, 32'd0);
            chk("jalr_busy_req", {31'd0, req_valid}, 32'd0);
        end
        jalr_rs1_busy = 1'b0;
        jalr_rs1_rdata = 32'h8000_1001;
        tick();
        chk("jalr_valid", {31'd0, ifu_valid}, 32'd1);
        chk("jalr_pred", {31'd0, ifu_pred_taken}, 32'd1);
        chk("jalr_pc", ifu_pc, 32'h8000_0014);
        chk("jalr_inst", ifu_inst, 32'h0042_8067);
        chk("jalr_next_addr", req_addr, 32'h8000_1004);

        // fence.i holds fetch until done
        issue(32'h8000_1004);
        respond(32'h0000_100F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 5'd0);
        chk("fence_valid", {31'd0, ifu_valid}, 32'd1);
        chk("fence_req", {31'd0, fencei_req}, 32'd1);
        chk("fence_no_req", {31'd0, req_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fence_req_held", {31'd0, fencei_req}, 32'd1);
            chk("fence_no_fetch", {31'd0, req_valid}, 32'd0);
        end
        fencei_done = 1'b1;
        tick();
        fencei_done = 1'b0;
        #1;
        chk("fence_req_drop", {31'd0, fencei_req}, 32'd0);
        chk("fence_resume_req", {31'd0, req_valid}, 32'd1);
        chk("fence_resume_addr", req_addr, 32'h8000_1008);

        // Redirect while waiting: the late response is discarded
        issue(32'h8000_1008);
        exu_redirect = 1'b1;
        exu_redirect_pc = 32'h8000_2000;
        tick();
        exu_redirect = 1'b0;
        #1;
        chk("drop_ifu_valid", {31'd0, ifu_valid}, 32'd0);
        chk("drop_no_req", {31'd0, req_valid}, 32'd0);
        chk("drop_addr", req_addr, 32'h8000_2000);
        respond(32'h1000_006F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 5'd0);
        chk("dropped_ifu_valid", {31'd0, ifu_valid}, 32'd0);
        chk("after_drop_req", {31'd0, req_valid}, 32'd1);
        chk("after_drop_addr", req_addr, 32'h8000_2000);

        // Decode back-pressure holds the output and blocks fetch
        ifu_ready = 1'b0;
        issue(32'h8000_2000);
        respond(32'h00A0_0093, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
        chk("bp_valid", {31'd0, ifu_valid}, 32'd1);
        chk("bp_pc", ifu_pc, 32'h8000_2000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_inst_stable", ifu_inst, 32'h00A0_0093);
            chk("bp_valid_held", {31'd0, ifu_valid}, 32'd1);
            chk("bp_no_req", {31'd0, req_valid}, 32'd0);
        end
        ifu_ready = 1'b1;
        issue(32'h8000_2004);
        #1;
        chk("bp_consumed", {31'd0, ifu_valid}, 32'd0);

        // Fetch fault halts until redirect
        respond(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
        chk("err_flag", {31'd0, ifu_err}, 32'd1);
        chk("err_valid", {31'd0, ifu_valid}, 32'd1);
        chk("err_pred", {31'd0, ifu_pred_taken}, 32'd0);
        chk("err_pc", ifu_pc, 32'h8000_2004);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_no_req", {31'd0, req_valid}, 32'd0);
        end
        exu_redirect = 1'b1;
        exu_redirect_pc = 32'h8000_3000;
        tick();
        exu_redirect = 1'b0;
        #1;
        chk("halt_exit_req", {31'd0, req_valid}, 32'd1);
        chk("halt_exit_addr", req_addr, 32'h8000_3000);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_addr", req_addr, 32'h8000_0000);
        chk("async_rst_req", {31'd0, req_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lieat_ifu_fetch_ctrl.md
Name: lieat_ifu_fetch_ctrl

Overview:
- Fetch sequencer for the IFU; owns the PC and issues one instruction-fetch request at a time to ITCM/ICache.
- Consumes the combinational predecode results for the returned instruction (bxx/jal/jalr/fence.i plus branch immediate) and applies static prediction.
- Handles jalr operand stalls, fence.i sequencing and EXU redirects.
- Delivers instruction, PC and prediction to the decode stage through a one-entry valid/ready output register.

Parameters:
- XLEN, 32, datapath/PC width.
- REG_IDX, 5, register index width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  XLEN  fetch address; bits [1:0] are always 0.
- rsp_valid  in  1  response pulse; cannot be back-pressured.
- rsp_inst  in  XLEN  returned instruction; also drives the external predecoder.
- rsp_err  in  1  bus/access fault with the response.
- pre_bxx  in  1  predecode: conditional branch.
- pre_jal  in  1  predecode: jal.
- pre_jalr  in  1  predecode: jalr.
- pre_fencei  in  1  predecode: fence.i.
- pre_imm  in  XLEN  predecode branch/jump immediate.
- pre_rs1  in  REG_IDX  predecode rs1 index.
- jalr_rs1_idx  out  REG_IDX  register read index for jalr.
- jalr_rs1_busy  in  1  scoreboard: rs1 has a pending write.
- jalr_rs1_rdata  in  XLEN  rs1 value, valid when busy=0.
- fencei_req  out  1  request for downstream drain / I-side invalidate.
- fencei_done  in  1  fence.i completion pulse.
- exu_redirect  in  1  mispredict/exception redirect.
- exu_redirect_pc  in  XLEN  redirect target.
- ifu_valid  out  1  decode-stage instruction valid.
- ifu_ready  in  1  decode stage accepts.
- ifu_inst  out  XLEN  instruction.
- ifu_pc  out  XLEN  instruction PC.
- ifu_pred_taken  out  1  static prediction taken.
- ifu_err  out  1  fetch fault flag.

Behaviour:
- Reset:
  - State=FETCH, pc=RESET_PC, drop=0.
  - All outputs 0 except req_addr=RESET_PC.
  - jalr_rs1_idx resets to 0.
- States: FETCH, WAIT, DROP, JWAIT, FWAIT, HALT.
- slot_free = ~ifu_valid | ifu_ready.
- FETCH:
  - req_valid = slot_free, req_addr = pc.
  - req_valid & req_ready -> WAIT. Exactly one outstanding request at any time.
- WAIT, on rsp_valid:
  - Load ifu_inst=rsp_inst, ifu_pc=pc, ifu_valid=1.
  - Compute next pc and next state with this priority:
    1. rsp_err: ifu_err=1, pred_taken=0 -> HALT.
    2. pre_jal: pc+pre_imm, taken -> FETCH.
    3. pre_bxx with pre_imm[XLEN-1]=1 (backward): pc+pre_imm, taken -> FETCH.
    4. pre_bxx forward: pc+4, not taken -> FETCH.
    5. pre_jalr: latch jalr_rs1_idx=pre_rs1 and the immediate -> JWAIT; ifu_valid stays 0 in this case, with inst/pc held internally.
    6. pre_fencei: deliver, pc+4 -> FWAIT.
    7. Otherwise: pc+4 -> FETCH.
  - All additions are modulo 2^XLEN.
- JWAIT:
  - When jalr_rs1_busy=0 and slot_free: ifu_valid=1, ifu_pred_taken=1, pc=(jalr_rs1_rdata+imm) & ~1 with bit1 forced 0 -> FETCH.
  - Minimum 1 cycle in JWAIT.
- FWAIT:
  - fencei_req=1 from entry until fencei_done; then -> FETCH, no new request issued before that.
  - fencei_done in the entry cycle is honoured.
- HALT: no requests; exits only on exu_redirect.
- Output register: holds its contents while ifu_valid & ~ifu_ready. Cleared on handshake unless reloaded in the same cycle.
- exu_redirect has the highest priority, in any state:
  - pc=exu_redirect_pc & ~3, ifu_valid=0, fencei_req=0.
  - If a request is outstanding (WAIT, or a request handshake in the same cycle) and no rsp_valid arrives that cycle -> DROP; otherwise -> FETCH.
- DROP: next rsp_valid is discarded (no output, no predecode effect) -> FETCH. A redirect during DROP updates pc and stays in DROP.
- Redirect coincident with rsp_valid in WAIT: response discarded -> FETCH.
- Reset asserted mid-operation: immediate return to reset values; the in-flight response after reset release is not expected.

Test Plan:
- Reset release, req_ready=1, rsp returns nop 0x00000013 one cycle later -> req_addr 0x80000000 then 0x80000004; ifu_pc=0x80000000, pred_taken=0.
- Branch beq imm=-8 at pc 0x80000010 -> ifu_pred_taken=1, next req_addr 0x80000008. Same branch with imm=+8 -> not taken, next req_addr 0x80000014.
- jalr with busy=1 for 3 cycles, then rs1=0x80001001, imm=4 -> ifu_valid rises only after busy drops; next req_addr 0x80001004.
- fence.i -> fencei_req held until fencei_done 5 cycles later; no req_valid meanwhile; then fetch pc+4.
- exu_redirect to 0x80002000 while in WAIT -> ifu_valid=0; the following rsp is dropped; next req_addr 0x80002000.
- ifu_ready=0 for 4 cycles with an instruction held -> ifu_inst stable and no req_valid until ready; then rsp_err=1 on the next fetch -> ifu_err=1 and no further requests until redirect.
